// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map constants and CLAIM packing for irq_ctrl
// Shared by irq_ctrl and irq_prio_enc.
package irq_ctrl_pkg;

  localparam int          NSRC_DEFAULT = 6;
  localparam logic [31:0] BASE_DEFAULT = 32'h0000_7F20;

  // Word offsets, i.e. Addr[4:2]
  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_MASK  = 3'd1;
  localparam logic [2:0] OFF_PEND  = 3'd2;
  localparam logic [2:0] OFF_MODE  = 3'd3;
  localparam logic [2:0] OFF_CLAIM = 3'd4;

  localparam int GIE_BIT       = 0;
  localparam int CLAIM_ANY_BIT = 31;
  localparam int CLAIM_VEC_LSB = 0;
  localparam int VEC_W         = 4;

  function automatic logic [31:0] claim_word(input logic any, input logic [VEC_W-1:0] vec);
    logic [31:0] w;
    w = '0;
    w[CLAIM_ANY_BIT] = any;
    w[CLAIM_VEC_LSB +: VEC_W] = vec;
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set index wins
// index is 0 when no request is present.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int W = NSRC_DEFAULT
) (
  input  logic [W-1:0]     req,
  output logic             valid,
  output logic [VEC_W-1:0] index
);

  // Scan from the top down so the lowest set bit is the last assignment.
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped level/edge interrupt controller (edge capture under IRQ_CTRL_EDGE_EN)
// Without IRQ_CTRL_EDGE_EN every source is level mode and MODE/PEND writes are dropped.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NSRC = NSRC_DEFAULT,
  parameter logic [31:0] BASE = BASE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     Addr,
  input  logic            WE,
  input  logic [31:0]     DataIn,
  output logic [31:0]     DataOut,
  input  logic [NSRC-1:0] Src,
  output logic            IRQ,
  output logic [3:0]      Vector
);

  logic            sel;
  logic [2:0]      off;
  logic            wr;
  logic            gie;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] mode;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_next;
  logic [NSRC-1:0] active;
  logic            any;
  logic [3:0]      vec;
  logic            unused_bits;

  assign sel = (Addr[31:5] == BASE[31:5]);
  assign off = Addr[4:2];
  assign wr  = WE & sel;

  assign unused_bits = &{1'b0, Addr[1:0], DataIn};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gie  <= 1'b0;
      mask <= '0;
    end else if (wr) begin
      if (off == OFF_CTRL) gie  <= DataIn[GIE_BIT];
      if (off == OFF_MASK) mask <= DataIn[NSRC-1:0];
    end
  end

`ifdef IRQ_CTRL_EDGE_EN
  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] w1c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode  <= '0;
      src_q <= '0;
    end else begin
      src_q <= Src;
      if (wr && off == OFF_MODE) mode <= DataIn[NSRC-1:0];
    end
  end

  assign rise = Src & ~src_q;
  assign w1c  = (wr && off == OFF_PEND) ? DataIn[NSRC-1:0] : '0;

  // Edge bits latch rises (set beats a same-cycle W1C); level bits follow the line.
  assign pend_next = (~mode & Src) | (mode & (rise | (pend & ~w1c)));
`else
  assign mode      = '0;
  assign pend_next = Src;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pend <= '0;
    else        pend <= pend_next;
  end

  assign active = pend & mask;

  irq_prio_enc #(.W(NSRC)) u_prio (
    .req   (active),
    .valid (any),
    .index (vec)
  );

  assign IRQ    = gie & any;
  assign Vector = vec;

  always_comb begin
    DataOut = '0;
    if (sel) begin
      case (off)
        OFF_CTRL:  DataOut[GIE_BIT]    = gie;
        OFF_MASK:  DataOut[NSRC-1:0]   = mask;
        OFF_PEND:  DataOut[NSRC-1:0]   = pend;
        OFF_MODE:  DataOut[NSRC-1:0]   = mode;
        OFF_CLAIM: DataOut             = claim_word(any, vec);
        default:   DataOut             = '0;
      endcase
    end
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller downstream of the timer and other peripheral devices. Collects up to `NSRC` device interrupt lines and latches them as level or edge events. It applies per-source masks and a global enable, and drives a single `IRQ` plus a source vector to CP0. Software programs and services it through the same `Addr`/`WE`/`DataIn`/`DataOut` bus the bridge uses for the other devices.

## Interface
- `NSRC`, 6 — number of interrupt sources (1..16).
- `BASE`, 32'h0000_7F20 — register block base address, 32-byte aligned.

- `clk` in 1 — sole clock, rising edge.
- `reset` in 1 — asynchronous, active-low; clears all state immediately.
- `Addr` in 32 — byte address from bridge.
- `WE` in 1 — write strobe, one cycle per write.
- `DataIn` in 32 — write data.
- `DataOut` out 32 — combinational read data for `Addr`.
- `Src` in NSRC — device interrupt lines; bit 0 is the timer.
- `IRQ` out 1 — interrupt request to CP0.
- `Vector` out 4 — index of the highest-priority active source; 0 when none.

## Operation
- Decode:
  - Block is selected when `Addr[31:5]==BASE[31:5]`.
  - Offset is `Addr[4:2]`.
  - Writes outside the block or to undefined offsets are ignored.
  - Reads of undefined offsets return 0.
- Registers:
  - 0x00 CTRL: bit0 GIE (global enable), R/W; other bits read 0.
  - 0x04 MASK[NSRC-1:0], R/W; 1 = source enabled.
  - 0x08 PEND[NSRC-1:0]: read returns pending bits. Writing 1 clears edge-mode bits; writes to level-mode bits are ignored.
  - 0x0C MODE[NSRC-1:0], R/W; 1 = edge, 0 = level.
  - 0x10 CLAIM, read-only: bit31 = any active, [3:0] = `Vector`.
- Per source i, `src_q[i]` is `Src[i]` registered every cycle.
  - Level mode: `pend[i] <= Src[i]`, so it tracks the line with 1-cycle delay.
  - Edge mode: `pend[i]` sets on a cycle where `Src[i] & ~src_q[i]`, and holds until W1C.
  - Set and W1C in the same cycle: set wins.
- Changing MODE from edge to level: `pend[i]` takes the level value on the next edge.
- `active = pend & MASK`.
- `IRQ = GIE & |active`, combinational from registers.
- `Vector` is the lowest-index set bit of `active` (fixed priority, bit 0 highest), or 0.
  - `Vector` does not depend on GIE.

## Timing
- Reset values: CTRL, MASK, MODE, pend, src_q = 0; `IRQ`=0, `Vector`=0, `DataOut`=0.
- Write latency: a register updates at the rising edge where `WE`=1; `IRQ` reflects it in the following cycle.
- Source latency:
  - `Src` rises before edge k → pend set at edge k.
  - `IRQ` high after edge k (1 cycle) when masked-in and GIE=1.
- Level deassert: `Src` falls before edge k → `IRQ` low after edge k.
- An edge-mode pulse of one cycle is captured.
- A line already high when switched to edge mode does not set pend until its next rising edge.
- Masked sources still set pend; unmasking a pending source raises `IRQ` in the same cycle as the MASK update.
- Reset asserted mid-operation: all state clears asynchronously, and `IRQ` drops without waiting for `clk`.

## Configuration
- `IRQ_CTRL_EDGE_EN` defined:
  - MODE register and edge capture are implemented as described.
- Undefined:
  - All sources are level mode.
  - MODE reads 0 and writes are ignored.
  - PEND writes have no effect.
  - Edge-detect logic is not synthesized.

## Structure
- Package `irq_ctrl_pkg`:
  - register offset constants (CTRL, MASK, PEND, MODE, CLAIM);
  - default `NSRC`;
  - CLAIM field positions.
- Sub-module `irq_prio_enc`: parameterised lowest-index priority encoder producing a valid flag and a 4-bit index.
  - Used for `Vector` and CLAIM.

## Test plan
- Reset, then read all offsets → all 0, `IRQ`=0.
- Level source 0:
  - Stimulus: write MASK=1 and CTRL=1, then hold `Src[0]`=1 for 3 cycles.
  - `IRQ` high 1 cycle after `Src[0]` rises; low 1 cycle after it falls; CLAIM=32'h8000_0000.
- Edge source 2:
  - Stimulus: MODE=4, MASK=4, GIE=1, then a single-cycle `Src[2]` pulse.
  - PEND=4 and `IRQ` stays high; write PEND=4 → `IRQ` low next cycle.
- Priority:
  - Stimulus: edge sources 1 and 3 pending, MASK=0xA.
  - `Vector`=1; W1C bit 1 → `Vector`=3.
- Collision: rising edge on edge source 2 in the same cycle as a W1C of bit 2 → PEND bit 2 remains 1.
- Reset mid-operation: with `IRQ`=1, pull `reset` low between clock edges → `IRQ`=0 immediately; registers read 0 after release.
